// File: rtl/cbus_arbiter_n_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cbus_arbiter_n_if : CBus request/response types and arbiter bus   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package cbus_arbiter_n_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_n_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_arbiter_n_pkg::*;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  cbus_req_t              ireqs  [NUM_INPUTS];
  cbus_resp_t             iresps [NUM_INPUTS];
  cbus_req_t              oreq;
  cbus_resp_t             oresp;
  logic [IDX_W-1:0]       owner;
  logic                   busy;

  // master: the arbiter itself; slave: the surrounding masters and memory model
  modport master (
    input  ireqs, oresp,
    output iresps, oreq, owner, busy
  );

  modport slave (
    output ireqs, oresp,
    input  iresps, oreq, owner, busy
  );

endinterface
`default_nettype wire

// File: rtl/cbus_arbiter_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cbus_arbiter_n : N-input CBus arbiter, grant held per transaction |
// | Round-robin selection when CBUS_ARB_RR_EN is defined. Rev 1.0     |
// +------------------------------------------------------------------+
module cbus_arbiter_n #(
  parameter int NUM_INPUTS = 2
) (
  input  logic             clk,
  input  logic             reset,
  cbus_arbiter_n_if.master bus
);
  import cbus_arbiter_n_pkg::*;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    winner;
  logic [NUM_INPUTS-1:0] vld;
  logic                grant;
  cbus_req_t           oreq_c;
  cbus_resp_t          iresps_c [NUM_INPUTS];

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      vld[i] = bus.ireqs[i].valid;
    end
  end

  assign grant = (state == S_IDLE) && (|vld);

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] pick_hi;
  logic [IDX_W-1:0] pick_any;
  logic             hi_found;

  // Lowest valid index above last wins, else wrap to the lowest valid index.
  always_comb begin
    pick_hi  = '0;
    pick_any = '0;
    hi_found = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (vld[i]) begin
        pick_any = IDX_W'(i);
      end
      if (vld[i] && (i > int'(last_q))) begin
        hi_found = 1'b1;
        pick_hi  = IDX_W'(i);
      end
    end
    winner = hi_found ? pick_hi : pick_any;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= IDX_W'(NUM_INPUTS - 1);
    end else if (grant) begin
      last_q <= winner;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (vld[i]) begin
        winner = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      owner_q <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner_q <= winner;
      end
    end
  end

  // BUSY is a pure pass-through; the owner keeps the grant until ready && last.
  always_comb begin
    state_nx = state;
    oreq_c   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps_c[i] = '0;
    end
    case (state)
      S_IDLE: begin
        if (|vld) begin
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        oreq_c            = bus.ireqs[owner_q];
        iresps_c[owner_q] = bus.oresp;
        if (bus.oresp.ready && bus.oresp.last) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.oreq   = oreq_c;
  assign bus.iresps = iresps_c;
  assign bus.owner  = owner_q;
  assign bus.busy   = (state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_cbus_arbiter_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cbus_arbiter_n : directed self-checking bench, N=2 and N=4     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_cbus_arbiter_n;
  import cbus_arbiter_n_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef CBUS_ARB_RR_EN
  int alt_exp  [4] = '{0, 1, 0, 1};
  int wrap_exp [5] = '{0, 1, 2, 3, 0};
`else
  int alt_exp  [4] = '{0, 0, 0, 0};
  int wrap_exp [5] = '{0, 0, 0, 0, 0};
`endif

  always #5 clk = ~clk;

  cbus_arbiter_n_if #(.NUM_INPUTS(2)) if2 ();
  cbus_arbiter_n_if #(.NUM_INPUTS(4)) if4 ();

  cbus_arbiter_n #(.NUM_INPUTS(2)) dut2 (.clk(clk), .reset(rst_n), .bus(if2));
  cbus_arbiter_n #(.NUM_INPUTS(4)) dut4 (.clk(clk), .reset(rst_n), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) if2.ireqs[i] = '0;
    for (int i = 0; i < 4; i++) if4.ireqs[i] = '0;
    if2.oresp = '0;
    if4.oresp = '0;

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy",  32'(if2.busy),  0);
    chk("rst_owner", 32'(if2.owner), 0);
    chk("rst_oreq",  32'(|if2.oreq), 0);
    chk("rst4_owner", 32'(if4.owner), 0);
    rst_n = 1'b1;
    tick();

    // single request from port 1
    if2.ireqs[1].valid = 1'b1;
    if2.ireqs[1].addr  = 32'h8000_0000;
    if2.ireqs[1].len   = 4'd0;
    settle();
    chk("single_t_valid", 32'(if2.oreq.valid), 0);
    tick();
    chk("single_t1_valid", 32'(if2.oreq.valid), 1);
    chk("single_t1_addr",  if2.oreq.addr, 32'h8000_0000);
    chk("single_owner",    32'(if2.owner), 1);
    chk("single_busy",     32'(if2.busy),  1);
    if2.oresp.ready = 1'b1;
    if2.oresp.last  = 1'b1;
    if2.oresp.data  = 32'hDEAD_BEEF;
    settle();
    chk("single_resp_data",  if2.iresps[1].data, 32'hDEAD_BEEF);
    chk("single_resp_ready", 32'(if2.iresps[1].ready), 1);
    chk("single_other_zero", 32'(|if2.iresps[0]), 0);
    if2.ireqs[1].valid = 1'b0;
    tick();
    if2.oresp = '0;
    settle();
    chk("single_rel_busy",  32'(if2.busy), 0);
    chk("single_rel_valid", 32'(if2.oreq.valid), 0);

    // both ports hold valid; slave completes every transaction in one beat
    if2.ireqs[0].valid = 1'b1;
    if2.ireqs[1].valid = 1'b1;
    if2.oresp.ready    = 1'b1;
    if2.oresp.last     = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("alt_owner%0d", g), 32'(if2.owner), 32'(alt_exp[g]));
      chk($sformatf("alt_busy%0d", g),  32'(if2.busy), 1);
      tick();
      chk($sformatf("alt_gap_busy%0d", g),  32'(if2.busy), 0);
      chk($sformatf("alt_gap_valid%0d", g), 32'(if2.oreq.valid), 0);
    end
    if2.ireqs[0].valid = 1'b0;
    if2.ireqs[1].valid = 1'b0;
    if2.oresp = '0;
    tick();

    // 4-beat burst on port 0, port 1 arrives during beat 2
    if2.ireqs[0].valid = 1'b1;
    if2.ireqs[0].addr  = 32'h0000_1000;
    if2.ireqs[0].len   = 4'd3;
    if2.ireqs[0].burst = 2'b01;
    tick();
    chk("burst_owner", 32'(if2.owner), 0);
    chk("burst_len",   32'(if2.oreq.len), 3);
    chk("burst_kind",  32'(if2.oreq.burst), 1);
    for (int b = 1; b <= 4; b++) begin
      if2.oresp.ready = 1'b1;
      if2.oresp.last  = (b == 4);
      if (b == 2) begin
        if2.ireqs[1].valid = 1'b1;
        if2.ireqs[1].addr  = 32'h0000_2000;
      end
      if (b == 4) if2.ireqs[0].valid = 1'b0;
      settle();
      chk($sformatf("burst_beat%0d_owner", b), 32'(if2.owner), 0);
      chk($sformatf("burst_beat%0d_busy", b),  32'(if2.busy), 1);
      tick();
    end
    if2.oresp = '0;
    settle();
    chk("burst_gap_busy",  32'(if2.busy), 0);
    chk("burst_gap_valid", 32'(if2.oreq.valid), 0);
    tick();
    chk("burst_next_owner", 32'(if2.owner), 1);
    chk("burst_next_addr",  if2.oreq.addr, 32'h0000_2000);
    if2.oresp.ready = 1'b1;
    if2.oresp.last  = 1'b1;
    if2.ireqs[1].valid = 1'b0;
    tick();
    if2.oresp = '0;
    settle();
    chk("burst_done_busy", 32'(if2.busy), 0);

    // reset during beat 2 of a burst on the 4-port arbiter
    if4.ireqs[0].valid = 1'b1;
    if4.ireqs[0].len   = 4'd3;
    tick();
    chk("rb_owner", 32'(if4.owner), 0);
    chk("rb_busy",  32'(if4.busy), 1);
    if4.oresp.ready = 1'b1;
    tick();
    settle();
    chk("rb_beat2_busy", 32'(if4.busy), 1);
    rst_n = 1'b0;
    tick();
    chk("rb_rst_busy",   32'(if4.busy), 0);
    chk("rb_rst_owner",  32'(if4.owner), 0);
    chk("rb_rst_oreq",   32'(|if4.oreq), 0);
    chk("rb_rst_iresp0", 32'(|if4.iresps[0]), 0);
    rst_n = 1'b1;
    if4.ireqs[0] = '0;
    if4.ireqs[2].valid = 1'b1;
    if4.ireqs[3].valid = 1'b1;
    if4.oresp = '0;
    tick();
    chk("rb_after_owner", 32'(if4.owner), 2);
    chk("rb_after_busy",  32'(if4.busy), 1);
    if4.oresp.ready = 1'b1;
    if4.oresp.data  = 32'h0000_0055;
    settle();
    chk("rb_iresp2_ready", 32'(if4.iresps[2].ready), 1);
    chk("rb_iresp3_zero",  32'(|if4.iresps[3]), 0);

    // wrap-around: fresh reset, all four ports valid
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) if4.ireqs[i].valid = 1'b1;
    if4.oresp.ready = 1'b1;
    if4.oresp.last  = 1'b1;
    tick();
    chk("wrap_rst_busy", 32'(if4.busy), 0);
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("wrap_owner%0d", g), 32'(if4.owner), 32'(wrap_exp[g]));
      tick();
      chk($sformatf("wrap_gap%0d", g), 32'(if4.busy), 0);
    end
    for (int i = 0; i < 4; i++) if4.ireqs[i] = '0;
    if4.oresp = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cbus_arbiter_n.md
# cbus_arbiter_n

Parametrised N-input CBus arbiter between the per-port bus converters (instruction, data, and any future masters such as a page-table walker or DMA) and the single downstream CBus slave (RAM helper / memory model). It selects one requester at a time, forwards that requester's complete transaction, including multi-beat bursts, and routes responses back only to the owner. It generalises the fixed two-input arbiter to any port count. It adds round-robin fairness and exposes the current grant for debug and perf.

## Interface
Parameters:
- NUM_INPUTS, default 2: number of requesting ports; legal range 1..16.
- IDX_W, default $clog2(NUM_INPUTS) with a minimum of 1: width of the owner index. Derived; not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-low reset; sampled on posedge clk.
- ireqs  input  cbus_req_t[NUM_INPUTS]  per-port requests; index 0 is the highest fixed priority.
- iresps  output  cbus_resp_t[NUM_INPUTS]  per-port responses.
- oreq  output  cbus_req_t  request to the downstream slave.
- oresp  input  cbus_resp_t  response from the downstream slave.
- owner  output  IDX_W  index of the granted port; valid only while busy=1.
- busy  output  1  a transaction is in progress.

## Operation
- The FSM has two states, IDLE and BUSY. Reset state is IDLE.
- **IDLE**
  - oreq='0 and every iresps[i]='0.
  - If any ireqs[i].valid is set, select a winner, register it into owner, and go to BUSY on the next edge.
- **BUSY**
  - oreq = ireqs[owner], a combinational pass-through of all fields, including len and burst.
  - iresps[owner] = oresp. All other iresps = '0.
  - When oresp.ready && oresp.last, go to IDLE on the next edge.
- **Selection**
  - Round-robin mode: search order is last+1, last+2, …, last+NUM_INPUTS, modulo NUM_INPUTS. The first port with valid=1 wins. last is updated to the winner on each grant.
  - Fixed-priority mode: the lowest-index valid port wins.
- **Owner drops valid in BUSY** (protocol violation): oreq.valid follows it; the arbiter stays in BUSY until ready&&last. No assertion is raised in RTL.
- **Burst:** the grant is held across all beats. A beat with ready=1 and last=0 does not release the grant.
- **Reset** (reset=0 at an edge, including mid-transaction):
  - state goes to IDLE; owner=0; busy=0; last=NUM_INPUTS-1, so port 0 has first priority after reset.
  - oreq and iresps become '0 in the following cycle.
- **NUM_INPUTS=1:** behaviour is identical apart from the single port, including the idle cycle between transactions.

## Timing
- Grant latency: a request first valid in cycle t (arbiter IDLE) appears on oreq in cycle t+1.
- Release: a response with ready&&last in cycle t means cycle t+1 is IDLE, so oreq.valid=0. The earliest next grant is visible on oreq at t+2.
- There is exactly one dead cycle between back-to-back transactions. This is guaranteed so the slave sees valid drop.
- The request and response paths are purely combinational in BUSY, so there is no added per-beat latency.
- owner and busy are registered outputs. Their reset values are owner=0 and busy=0.
- Simultaneous events:
  - ready&&last in the same cycle as new requests: new requests are ignored until IDLE.
  - A request arriving in the release cycle is arbitrated in the next (IDLE) cycle.

## Configuration
- The macro is CBUS_ARB_RR_EN.
- Defined: round-robin selection as described above, with the `last` register present.
- Undefined: fixed priority (lowest index wins). The `last` register is not synthesised. Everything else is identical, including latencies and reset values.

## Test plan
- **Single request:** NUM_INPUTS=2, port 1 reads addr 0x8000_0000, len=0. Required:
  - oreq.valid=1 at t+1, owner=1.
  - iresps[1] mirrors oresp; iresps[0]='0.
  - The cycle after ready&&last, busy=0.
- **Round-robin alternation** (CBUS_ARB_RR_EN): ports 0 and 1 hold valid continuously. Grants go 0,1,0,1, with one IDLE cycle between each.
- **Fixed priority** (macro undefined): ports 0 and 1 hold valid continuously. Port 0 is granted every time; port 1 is never granted while port 0 stays valid.
- **Burst:** port 0 issues len=3 (4 beats), the slave returns ready on 4 beats with last on the 4th. Required:
  - owner stays 0 and busy stays 1 through beat 4.
  - A port-1 request raised during beat 2 is granted only after the IDLE cycle.
- **Reset mid-burst:** reset=0 during beat 2. Required:
  - Next cycle busy=0, owner=0, oreq='0.
  - After reset=1 with ports 2 and 3 valid (NUM_INPUTS=4, RR), port 2 wins. That is correct because the search starts at 0 and ports 0–1 are idle.
- **Wrap-around:** NUM_INPUTS=4, RR, all ports valid, starting with last=3. Grant order is 0,1,2,3,0.
